// File: rtl/mips_mem_pkg.sv
// Shared encodings and lane helpers for the MIPS MEM stage.
package mips_mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Half must be 2-byte aligned, word 4-byte aligned. Reserved size 11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return lane[0];
            default:  return lane != 2'b00;
        endcase
    endfunction

    // Byte-enable mask, little-endian (bit 0 = bits 7:0 of the word).
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_BYTE: return 4'b0001 << lane;
            MEM_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so the mask alone selects what lands.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            MEM_BYTE: return {4{data[7:0]}};
            MEM_HALF: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

    // Pick the addressed lane out of a read word and sign/zero extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_BYTE: return sext ? {{24{b[7]}}, b} : {24'h0, b};
            MEM_HALF: return sext ? {{16{h[15]}}, h} : {16'h0, h};
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: byte-enable synchronous write, synchronous read.
// Optional combinational debug read port under DATA_MEM_DEBUG_EN.
module data_memory
    import mips_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    wmask,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
`ifdef DATA_MEM_DEBUG_EN
    ,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
`endif
);

    logic [31:0] mem [MEM_DEPTH];

    // Per-byte write; read returns the pre-write word (caller never reads and writes together).
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (re) rdata <= mem[addr];
    end

`ifdef DATA_MEM_DEBUG_EN
    assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: alignment check, branch resolve, data memory and MEM/WB register.
// Optional macro DATA_MEM_DEBUG_EN adds i_dbgAddr/o_dbgData memory dump port.
module memory_stage
    import mips_mem_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_BITS_REG = 5,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [N_BITS-1:0]     i_aluResult,
    input  logic [N_BITS-1:0]     i_datoLeido2,
    input  logic [N_BITS-1:0]     i_branchTarget,
    input  logic [N_BITS_REG-1:0] i_rd,
    input  logic                  i_ceroSignal,
    input  logic                  i_branch,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic                  i_memToReg,
    input  logic                  i_regWrite,
    input  logic [1:0]            i_memSize,
    input  logic                  i_memSigned,
`ifdef DATA_MEM_DEBUG_EN
    input  logic [$clog2(MEM_DEPTH)-1:0] i_dbgAddr,
    output logic [N_BITS-1:0]     o_dbgData,
`endif
    output logic                  o_pcSrc,
    output logic [N_BITS-1:0]     o_branchTarget,
    output logic [N_BITS-1:0]     o_fwdData,
    output logic [N_BITS-1:0]     o_readData,
    output logic [N_BITS-1:0]     o_aluResult,
    output logic [N_BITS_REG-1:0] o_rd,
    output logic                  o_memToReg,
    output logic                  o_regWrite,
    output logic                  o_misaligned
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [1:0]    lane;
    logic [AW-1:0] word_idx;
    logic          misaligned, do_store, do_load;
    logic [3:0]    wmask;
    logic [31:0]   rword;
    // Load shape captured with the read so extraction happens after the RAM register.
    logic          ld_valid, ld_sext;
    logic [1:0]    ld_size, ld_lane;

    assign lane       = i_aluResult[1:0];
    assign word_idx   = i_aluResult[AW+1:2];
    assign misaligned = (i_memRead | i_memWrite) & is_misaligned(i_memSize, lane);
    // Reset on the edge suppresses the store even though the RAM itself has no reset.
    assign do_store   = i_enable & i_memWrite & ~misaligned & ~i_reset;
    assign do_load    = i_enable & i_memRead & ~i_memWrite & ~misaligned;
    assign wmask      = do_store ? byte_mask(i_memSize, lane) : 4'b0000;

    assign o_pcSrc        = i_branch & i_ceroSignal;
    assign o_branchTarget = i_branchTarget;
    assign o_fwdData      = i_aluResult;

    data_memory #(.MEM_DEPTH(MEM_DEPTH)) u_dmem (
        .clk      (i_clk),
        .wmask    (wmask),
        .re       (do_load),
        .addr     (word_idx),
        .wdata    (store_lanes(i_memSize, i_datoLeido2)),
        .rdata    (rword)
`ifdef DATA_MEM_DEBUG_EN
        ,
        .dbg_addr (i_dbgAddr),
        .dbg_data (o_dbgData)
`endif
    );

    // ld_valid resets, so o_readData clears immediately on reset and holds on stall.
    assign o_readData = ld_valid ? load_extract(rword, ld_size, ld_lane, ld_sext) : '0;

    // MEM/WB register plus sticky misaligned flag; everything holds while stalled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_aluResult  <= '0;
            o_rd         <= '0;
            o_memToReg   <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
            ld_valid     <= 1'b0;
            ld_sext      <= 1'b0;
            ld_size      <= 2'b00;
            ld_lane      <= 2'b00;
        end else if (i_enable) begin
            o_aluResult <= i_aluResult;
            o_rd        <= i_rd;
            o_memToReg  <= i_memToReg;
            o_regWrite  <= i_regWrite;
            ld_valid    <= do_load;
            ld_sext     <= i_memSigned;
            ld_size     <= i_memSize;
            ld_lane     <= lane;
            if (misaligned) o_misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised + directed bench for memory_stage against a byte-array reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable, i_ceroSignal, i_branch, i_memRead, i_memWrite;
    logic        i_memToReg, i_regWrite, i_memSigned;
    logic [31:0] i_aluResult, i_datoLeido2, i_branchTarget;
    logic [4:0]  i_rd;
    logic [1:0]  i_memSize;
    logic        o_pcSrc, o_memToReg, o_regWrite, o_misaligned;
    logic [31:0] o_branchTarget, o_fwdData, o_readData, o_aluResult;
    logic [4:0]  o_rd;
`ifdef DATA_MEM_DEBUG_EN
    logic [7:0]  i_dbgAddr = '0;
    logic [31:0] o_dbgData;
`endif

    memory_stage dut (
        .i_clk(clk), .i_reset(rst), .i_enable(i_enable),
        .i_aluResult(i_aluResult), .i_datoLeido2(i_datoLeido2),
        .i_branchTarget(i_branchTarget), .i_rd(i_rd), .i_ceroSignal(i_ceroSignal),
        .i_branch(i_branch), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
        .i_memToReg(i_memToReg), .i_regWrite(i_regWrite),
        .i_memSize(i_memSize), .i_memSigned(i_memSigned),
`ifdef DATA_MEM_DEBUG_EN
        .i_dbgAddr(i_dbgAddr), .o_dbgData(o_dbgData),
`endif
        .o_pcSrc(o_pcSrc), .o_branchTarget(o_branchTarget), .o_fwdData(o_fwdData),
        .o_readData(o_readData), .o_aluResult(o_aluResult), .o_rd(o_rd),
        .o_memToReg(o_memToReg), .o_regWrite(o_regWrite), .o_misaligned(o_misaligned)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: flat byte memory (1024 bytes) and expected MEM/WB contents.
    logic [7:0]  mdl [0:1023];
    logic [31:0] e_rdata, e_alu;
    logic [4:0]  e_rd;
    logic        e_mtr, e_rw, e_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_load(input logic [9:0] a, input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        b = mdl[a];
        h = {mdl[a+10'd1], mdl[a]};
        if (sz == 2'd0) return sg ? 32'($signed(b)) : {24'h0, b};
        if (sz == 2'd1) return sg ? 32'($signed(h)) : {16'h0, h};
        return {mdl[a+10'd3], mdl[a+10'd2], mdl[a+10'd1], mdl[a]};
    endfunction

    task automatic mdl_store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) mdl[a + 10'(k)] = d[8*k +: 8];
    endtask

    task automatic mdl_reset();
        e_rdata = 0; e_alu = 0; e_rd = 0; e_mtr = 0; e_rw = 0; e_mis = 0;
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, "_rdata"}, o_readData, e_rdata);
        chk({pfx, "_alu"}, o_aluResult, e_alu);
        chk({pfx, "_rd"}, 32'(o_rd), 32'(e_rd));
        chk({pfx, "_mtr"}, 32'(o_memToReg), 32'(e_mtr));
        chk({pfx, "_rw"}, 32'(o_regWrite), 32'(e_rw));
        chk({pfx, "_mis"}, 32'(o_misaligned), 32'(e_mis));
    endtask

    task automatic drive(input logic en, input logic mr, input logic mw, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] data);
        i_enable = en; i_memRead = mr; i_memWrite = mw; i_memSize = sz; i_memSigned = sg;
        i_aluResult = addr; i_datoLeido2 = data;
        i_rd = 5'($urandom); i_memToReg = 1'($urandom); i_regWrite = 1'($urandom);
        i_branch = 1'($urandom); i_ceroSignal = 1'($urandom); i_branchTarget = $urandom;
    endtask

    // Check combinational outputs, advance the model, clock once, check MEM/WB.
    task automatic step();
        logic [9:0] a;
        logic       mis;
        #1;
        chk("pc_src", 32'(o_pcSrc), 32'(i_branch & i_ceroSignal));
        chk("br_tgt", o_branchTarget, i_branchTarget);
        chk("fwd", o_fwdData, i_aluResult);
        if (!rst && i_enable) begin
            a   = i_aluResult[9:0];
            mis = (i_memRead || i_memWrite) &&
                  ((i_memSize == 2'd1 && a[0]) || (i_memSize[1] && a[1:0] != 2'd0));
            e_alu = i_aluResult; e_rd = i_rd; e_mtr = i_memToReg; e_rw = i_regWrite;
            if (mis) e_mis = 1'b1;
            e_rdata = (i_memRead && !i_memWrite && !mis) ? mdl_load(a, i_memSize, i_memSigned) : 32'h0;
            if (i_memWrite && !mis) mdl_store(a, i_memSize, i_datoLeido2);
        end
        @(posedge clk);
        #1;
        check_regs("reg");
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        mdl_reset();
        check_regs("rst");
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mdl[i] = 8'h0;
        rst = 1'b1;
        drive(0, 0, 0, 2'd2, 0, 32'h0, 32'h0);
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("por");
        rst = 1'b0;

        // Known contents for words 0..15 (the whole region the bench touches).
        for (int w = 0; w < 16; w++) begin
            drive(1, 0, 1, 2'd2, 0, 32'(w * 4), 32'h0);
            step();
        end

        drive(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF); step();
        drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);        step();
        chk("ld_word", o_readData, 32'hDEADBEEF);
        chk("ld_word_mis", 32'(o_misaligned), 32'h0);
        drive(1, 1, 0, 2'd0, 1, 32'h13, 32'h0);        step();
        chk("ld_byte_s", o_readData, 32'hFFFFFFDE);
        drive(1, 1, 0, 2'd0, 0, 32'h13, 32'h0);        step();
        chk("ld_byte_u", o_readData, 32'h000000DE);
        drive(1, 1, 0, 2'd1, 1, 32'h12, 32'h0);        step();
        chk("ld_half_s", o_readData, 32'hFFFFDEAD);
        drive(1, 0, 1, 2'd0, 0, 32'h11, 32'hAABBCC55); step();
        drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);        step();
        chk("ld_after_sb", o_readData, 32'hDEAD55EF);

        // Misaligned word store: suppressed, flag sticks.
        drive(1, 0, 1, 2'd2, 0, 32'h22, 32'h12345678); step();
        chk("mis_set", 32'(o_misaligned), 32'h1);
        drive(1, 1, 0, 2'd2, 0, 32'h20, 32'h0);        step();
        chk("mis_no_store", o_readData, 32'h0);
        chk("mis_sticky", 32'(o_misaligned), 32'h1);

        // Branch resolution is combinational.
        drive(1, 0, 0, 2'd2, 0, 32'h0, 32'h0);
        i_branch = 1'b1; i_ceroSignal = 1'b1; i_branchTarget = 32'h40;
        #1;
        chk("br_taken", 32'(o_pcSrc), 32'h1);
        chk("br_target", o_branchTarget, 32'h40);
        i_ceroSignal = 1'b0;
        step();
        chk("br_not_taken", 32'(o_pcSrc), 32'h0);

        // Stall with a store pending: nothing moves.
        drive(0, 0, 1, 2'd2, 0, 32'h10, 32'h0); step();
        drive(0, 1, 0, 2'd2, 0, 32'h14, 32'h0); step();
        drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0); step();
        chk("stall_no_store", o_readData, 32'hDEAD55EF);

        // Reset between edges, then reset held across an edge with a store.
        async_reset();
        chk("rst_clears_mis", 32'(o_misaligned), 32'h0);
        drive(1, 0, 1, 2'd2, 0, 32'h20, 32'hCAFEF00D);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1, 1, 0, 2'd2, 0, 32'h20, 32'h0); step();
        chk("rst_no_store", o_readData, 32'h0);

        // Address wrap: high bits are ignored.
        drive(1, 0, 1, 2'd2, 0, 32'h414, 32'h0BADF00D); step();
        drive(1, 1, 0, 2'd2, 0, 32'h14, 32'h0);        step();
        chk("wrap", o_readData, 32'h0BADF00D);
        drive(1, 0, 1, 2'd2, 0, 32'h18, 32'h5A5A1234); step();
        drive(1, 1, 0, 2'd1, 0, 32'h1A, 32'h0);        step();
        chk("b2b_half", o_readData, 32'h00005A5A);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom), $urandom & 32'hFFFF_FC3F, $urandom);
            step();
            if (i == 200) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
